// File: rtl/pump_lead_lag_scheduler.sv
// Lead/lag scheduler for two tank-station pumps: rotation, staggered lag start, min on/off, failover.
// Optional run-cycle counters rt1/rt2 are built only when PUMP_RUNTIME_EN is defined.
module pump_lead_lag_scheduler #(
    parameter int MIN_ON  = 4,
    parameter int STAGGER = 2,
    parameter int MIN_OFF = 3,
    parameter int TW      = 4
) (
    input  logic        clk,
    input  logic        R,
    input  logic        I,
    input  logic        S,
    input  logic        F1,
    input  logic        F2,
    output logic        B1,
    output logic        B2,
    output logic        lead,
    output logic        alarm,
    output logic [15:0] rt1,
    output logic [15:0] rt2
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_LEAD,
        ST_RUN_BOTH,
        ST_REST,
        ST_FAULT
    } state_t;

    localparam logic [TW-1:0] MIN_ON_T  = TW'(MIN_ON);
    localparam logic [TW-1:0] STAGGER_T = TW'(STAGGER);
    localparam logic [TW-1:0] MIN_OFF_T = TW'(MIN_OFF);

    state_t        state_q, state_d;
    logic          lead_q, lead_d;
    logic          run_q, run_d;      // pump currently carrying the single-pump load
    logic [TW-1:0] on_q, on_d;
    logic [TW-1:0] stg_q, stg_d;
    logic [TW-1:0] off_q, off_d;
    logic          b1_q, b1_d;
    logic          b2_q, b2_d;
    logic          alarm_q, alarm_d;

    logic          av1, av2, se, cur_av, lag_av, start_pump;
    logic [TW-1:0] on_inc, stg_inc, off_inc;

    assign av1    = ~F1;
    assign av2    = ~F2;
    assign se     = S & I;
    assign cur_av = run_q ? av2 : av1;
    assign lag_av = run_q ? av1 : av2;
    assign start_pump = (lead_q ? av2 : av1) ? lead_q : ~lead_q;

    assign on_inc  = (on_q == MIN_ON_T) ? on_q : on_q + 1'b1;
    assign stg_inc = !se ? '0 : ((stg_q == STAGGER_T) ? stg_q : stg_q + 1'b1);
    assign off_inc = off_q + 1'b1;

    // NOTE: every variable gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        run_d   = run_q;
        on_d    = on_q;
        stg_d   = stg_q;
        off_d   = off_q;

        if (state_q != ST_REST && !av1 && !av2) begin
            state_d = ST_FAULT;
            stg_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (I) begin
                        state_d = ST_RUN_LEAD;
                        run_d   = start_pump;
                        on_d    = '0;
                        stg_d   = '0;
                    end
                end
                ST_RUN_LEAD: begin
                    on_d = on_inc;
                    if (!cur_av) begin
                        // bumpless handover to the healthy pump, which becomes lead
                        run_d  = ~run_q;
                        lead_d = ~run_q;
                        stg_d  = '0;
                    end else if (!I && on_inc == MIN_ON_T) begin
                        state_d = ST_REST;
                        off_d   = '0;
                        lead_d  = ~lead_q;
                    end else begin
                        stg_d = stg_inc;
                        if (stg_inc == STAGGER_T && lag_av) state_d = ST_RUN_BOTH;
                    end
                end
                ST_RUN_BOTH: begin
                    on_d  = on_inc;
                    stg_d = '0;
                    if (!cur_av) begin
                        state_d = ST_RUN_LEAD;
                        run_d   = ~run_q;
                        lead_d  = ~run_q;
                    end else if (!lag_av) begin
                        state_d = ST_RUN_LEAD;
                        lead_d  = run_q;
                    end else if (!I && on_inc == MIN_ON_T) begin
                        state_d = ST_REST;
                        off_d   = '0;
                        lead_d  = ~lead_q;
                    end else if (!se) begin
                        state_d = ST_RUN_LEAD;
                    end
                end
                ST_REST: begin
                    off_d = off_inc;
                    if (off_inc == MIN_OFF_T) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    state_d = ST_REST;
                    off_d   = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear one edge after the inputs.
    assign b1_d    = (state_d == ST_RUN_BOTH) | ((state_d == ST_RUN_LEAD) & ~run_d);
    assign b2_d    = (state_d == ST_RUN_BOTH) | ((state_d == ST_RUN_LEAD) &  run_d);
    assign alarm_d = (state_d == ST_FAULT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= ST_IDLE;
            lead_q  <= 1'b0;
            run_q   <= 1'b0;
            on_q    <= '0;
            stg_q   <= '0;
            off_q   <= '0;
            b1_q    <= 1'b0;
            b2_q    <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            run_q   <= run_d;
            on_q    <= on_d;
            stg_q   <= stg_d;
            off_q   <= off_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            alarm_q <= alarm_d;
        end
    end

    assign B1    = b1_q;
    assign B2    = b2_q;
    assign lead  = lead_q;
    assign alarm = alarm_q;

`ifdef PUMP_RUNTIME_EN
    logic [15:0] rt1_q, rt2_q;

    always_ff @(posedge clk) begin
        if (R) begin
            rt1_q <= '0;
            rt2_q <= '0;
        end else begin
            if (b1_q && rt1_q != 16'hFFFF) rt1_q <= rt1_q + 16'd1;
            if (b2_q && rt2_q != 16'hFFFF) rt2_q <= rt2_q + 16'd1;
        end
    end

    assign rt1 = rt1_q;
    assign rt2 = rt2_q;
`else
    assign rt1 = 16'd0;
    assign rt2 = 16'd0;
`endif

endmodule
